// File: rtl/down_mod_counter.sv
// Parametrised modulo-N down counter stage with load, enable, cascade borrow and one-shot expiry.
// Latency: one clock from reset/load/enable to q_bus; zero and borrow_out are combinational.
// Backpressure: none; enable acts as the borrow-in from the previous stage and is sampled every edge.
module down_mod_counter #(
  parameter int WIDTH    = 3,
  parameter int MODULUS  = 6,
  parameter int ONE_SHOT = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] q_bus,
  output logic             zero,
  output logic             borrow_out,
  output logic             expired
);

  // Top of the count range; also the wrap target and the load clamp ceiling.
  localparam logic [WIDTH-1:0] LP_MAX = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] LP_ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_next;
  logic [WIDTH-1:0] w_load_clamped;
  logic             r_expired;
  logic             w_expired_next;
  logic             w_zero;
  logic             w_step;

  assign w_zero = (r_q == '0);

  // A real decrement request this cycle: load always wins over enable.
  assign w_step = enable & ~load;

  // Out-of-range load values saturate to the top of the count range.
  always_comb begin
    w_load_clamped = load_value;
    if (load_value > LP_MAX) begin
      w_load_clamped = LP_MAX;
    end
  end

  // Next count: load, else decrement / wrap / hold-at-zero, else hold.
  // Values above LP_MAX (only reachable by forcing) simply decrement back into range.
  always_comb begin
    w_q_next = r_q;
    if (load) begin
      w_q_next = w_load_clamped;
    end else if (enable) begin
      if (!w_zero) begin
        w_q_next = r_q - LP_ONE;
      end else if (ONE_SHOT == 0) begin
        w_q_next = LP_MAX;
      end
    end
  end

  generate
    if (ONE_SHOT != 0) begin : g_one_shot
      // Expiry marks only the 1 -> 0 step, so sitting at zero never re-fires it.
      assign w_expired_next = w_step & (r_q == LP_ONE);
      assign borrow_out     = 1'b0;
    end else begin : g_wrap
      assign w_expired_next = 1'b0;
      // Same-cycle borrow so the next stage decrements on the wrap edge itself.
      assign borrow_out     = w_step & w_zero & ~reset;
    end
  endgenerate

  // Count and expiry registers; reset beats load and enable and drops a pending expiry.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_q       <= '0;
      r_expired <= 1'b0;
    end else begin
      r_q       <= w_q_next;
      r_expired <= w_expired_next;
    end
  end

  assign q_bus   = r_q;
  assign zero    = w_zero;
  assign expired = r_expired;

endmodule

// File: tb/tb_down_mod_counter.sv
// Bench for down_mod_counter: wrap stage, one-shot stage and a units/tens cascade.
// Stimulus pushes the expected outputs for each cycle; a monitor pops and compares them.
// No backpressure; the monitor drains every pushed expectation each cycle.
module tb_down_mod_counter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // Wrap-mode stage, WIDTH=3 MODULUS=6.
  logic       w_rst, w_en, w_ld;
  logic [2:0] w_lv, w_q;
  logic       w_z, w_b, w_e;

  // One-shot stage, WIDTH=4 MODULUS=10.
  logic       o_rst, o_en, o_ld;
  logic [3:0] o_lv, o_q;
  logic       o_z, o_b, o_e;

  // Cascade: units (mod 10) borrow drives tens (mod 6) enable.
  logic       c_rst, c_ld, u_en;
  logic [3:0] u_lv, u_q;
  logic [2:0] t_lv, t_q;
  logic       u_z, u_b, u_e, t_z, t_b, t_e;

  down_mod_counter #(.WIDTH(3), .MODULUS(6), .ONE_SHOT(0)) u_wrap (
    .clock(clock), .reset(w_rst), .enable(w_en), .load(w_ld), .load_value(w_lv),
    .q_bus(w_q), .zero(w_z), .borrow_out(w_b), .expired(w_e));

  down_mod_counter #(.WIDTH(4), .MODULUS(10), .ONE_SHOT(1)) u_os (
    .clock(clock), .reset(o_rst), .enable(o_en), .load(o_ld), .load_value(o_lv),
    .q_bus(o_q), .zero(o_z), .borrow_out(o_b), .expired(o_e));

  down_mod_counter #(.WIDTH(4), .MODULUS(10), .ONE_SHOT(0)) u_units (
    .clock(clock), .reset(c_rst), .enable(u_en), .load(c_ld), .load_value(u_lv),
    .q_bus(u_q), .zero(u_z), .borrow_out(u_b), .expired(u_e));

  down_mod_counter #(.WIDTH(3), .MODULUS(6), .ONE_SHOT(0)) u_tens (
    .clock(clock), .reset(c_rst), .enable(u_b), .load(c_ld), .load_value(t_lv),
    .q_bus(t_q), .zero(t_z), .borrow_out(t_b), .expired(t_e));

  typedef struct packed {
    logic [1:0] id;
    logic [3:0] q;
    logic       z;
    logic       b;
    logic       e;
  } exp_t;

  exp_t  sb_q[$];
  string nm_q[$];
  int    checks = 0;
  int    errors = 0;

  task automatic exp_push(input logic [1:0] id, input string nm, input logic [3:0] q,
                          input logic z, input logic b, input logic e);
    exp_t x;
    x.id = id; x.q = q; x.z = z; x.b = b; x.e = e;
    sb_q.push_back(x);
    nm_q.push_back(nm);
  endtask

  // Monitor: mid-cycle after the stimulus edge, compare every pending expectation.
  initial begin
    exp_t       x;
    string      nm;
    logic [3:0] aq;
    logic       az, ab, ae;
    forever begin
      @(negedge clock);
      #2;
      while (sb_q.size() > 0) begin
        x  = sb_q.pop_front();
        nm = nm_q.pop_front();
        case (x.id)
          2'd0:    begin aq = {1'b0, w_q}; az = w_z; ab = w_b; ae = w_e; end
          2'd1:    begin aq = o_q;         az = o_z; ab = o_b; ae = o_e; end
          2'd2:    begin aq = u_q;         az = u_z; ab = u_b; ae = u_e; end
          default: begin aq = {1'b0, t_q}; az = t_z; ab = t_b; ae = t_e; end
        endcase
        checks++;
        if ((aq !== x.q) || (az !== x.z) || (ab !== x.b) || (ae !== x.e)) begin
          errors++;
          $display("FAIL %s: got q=%0d zero=%b borrow=%b expired=%b, want q=%0d zero=%b borrow=%b expired=%b",
                   nm, aq, az, ab, ae, x.q, x.z, x.b, x.e);
        end
      end
    end
  end

  initial begin
    w_rst = 1'b1; w_en = 1'b0; w_ld = 1'b0; w_lv = '0;
    o_rst = 1'b1; o_en = 1'b0; o_ld = 1'b0; o_lv = '0;
    c_rst = 1'b1; c_ld = 1'b0; u_en = 1'b0; u_lv = '0; t_lv = '0;

    // ---- Wrap stage: reset state, load 5, seven enabled cycles ----
    @(negedge clock); w_rst = 1'b0; w_ld = 1'b1; w_lv = 3'd5; w_en = 1'b0;
    exp_push(2'd0, "wrap_reset", 4'd0, 1'b1, 1'b0, 1'b0);
    @(negedge clock); w_ld = 1'b0; w_en = 1'b1;
    exp_push(2'd0, "wrap_q5", 4'd5, 1'b0, 1'b0, 1'b0);
    for (int k = 4; k >= 1; k--) begin
      @(negedge clock);
      exp_push(2'd0, "wrap_down", 4'(k), 1'b0, 1'b0, 1'b0);
    end
    @(negedge clock);
    exp_push(2'd0, "wrap_zero_borrow", 4'd0, 1'b1, 1'b1, 1'b0);
    @(negedge clock);
    exp_push(2'd0, "wrap_back_to_5", 4'd5, 1'b0, 1'b0, 1'b0);

    // ---- Hold at 4 for four cycles ----
    @(negedge clock); w_en = 1'b0;
    exp_push(2'd0, "hold_4", 4'd4, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      exp_push(2'd0, "hold_4", 4'd4, 1'b0, 1'b0, 1'b0);
    end

    // ---- Load priority and clamp ----
    @(negedge clock); w_en = 1'b1;
    exp_push(2'd0, "step_to_3", 4'd4, 1'b0, 1'b0, 1'b0);
    @(negedge clock); w_ld = 1'b1; w_lv = 3'd7; w_en = 1'b1;
    exp_push(2'd0, "load_vs_enable_q3", 4'd3, 1'b0, 1'b0, 1'b0);
    @(negedge clock); w_lv = 3'd2; w_en = 1'b0;
    exp_push(2'd0, "clamp_to_5", 4'd5, 1'b0, 1'b0, 1'b0);
    @(negedge clock); w_ld = 1'b0;
    exp_push(2'd0, "load_2", 4'd2, 1'b0, 1'b0, 1'b0);

    // ---- Reset mid-operation, wrap mode ----
    @(negedge clock); w_rst = 1'b1; w_en = 1'b1; w_ld = 1'b1; w_lv = 3'd3;
    exp_push(2'd0, "wrap_pre_reset", 4'd2, 1'b0, 1'b0, 1'b0);
    @(negedge clock); w_rst = 1'b0; w_ld = 1'b0; w_en = 1'b1;
    exp_push(2'd0, "wrap_post_reset", 4'd0, 1'b1, 1'b1, 1'b0);
    @(negedge clock); w_en = 1'b0;
    exp_push(2'd0, "wrap_after_reset_5", 4'd5, 1'b0, 1'b0, 1'b0);

    // ---- One-shot stage: load 3, six enabled cycles ----
    @(negedge clock); o_rst = 1'b0; o_ld = 1'b1; o_lv = 4'd3; o_en = 1'b0;
    exp_push(2'd1, "os_reset", 4'd0, 1'b1, 1'b0, 1'b0);
    @(negedge clock); o_ld = 1'b0; o_en = 1'b1;
    exp_push(2'd1, "os_q3", 4'd3, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    exp_push(2'd1, "os_q2", 4'd2, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    exp_push(2'd1, "os_q1", 4'd1, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    exp_push(2'd1, "os_expired", 4'd0, 1'b1, 1'b0, 1'b1);
    @(negedge clock);
    exp_push(2'd1, "os_hold0_a", 4'd0, 1'b1, 1'b0, 1'b0);
    @(negedge clock);
    exp_push(2'd1, "os_hold0_b", 4'd0, 1'b1, 1'b0, 1'b0);

    // ---- One-shot: reset on the 1 -> 0 edge suppresses expiry ----
    @(negedge clock); o_en = 1'b0; o_ld = 1'b1; o_lv = 4'd2;
    exp_push(2'd1, "os_idle_load2", 4'd0, 1'b1, 1'b0, 1'b0);
    @(negedge clock); o_ld = 1'b0; o_en = 1'b1;
    exp_push(2'd1, "os_q2_again", 4'd2, 1'b0, 1'b0, 1'b0);
    @(negedge clock); o_rst = 1'b1; o_ld = 1'b1; o_lv = 4'd5; o_en = 1'b1;
    exp_push(2'd1, "os_pre_reset", 4'd1, 1'b0, 1'b0, 1'b0);
    @(negedge clock); o_rst = 1'b0; o_ld = 1'b0; o_en = 1'b1;
    exp_push(2'd1, "os_post_reset", 4'd0, 1'b1, 1'b0, 1'b0);
    @(negedge clock); o_ld = 1'b1; o_lv = 4'd15; o_en = 1'b0;
    exp_push(2'd1, "os_no_reexpire", 4'd0, 1'b1, 1'b0, 1'b0);
    @(negedge clock); o_ld = 1'b0;
    exp_push(2'd1, "os_clamp_9", 4'd9, 1'b0, 1'b0, 1'b0);

    // ---- Cascade: 50 -> 49 -> 48, then 00 -> 59 ----
    @(negedge clock); c_rst = 1'b0; c_ld = 1'b1; u_lv = 4'd0; t_lv = 3'd5; u_en = 1'b0;
    exp_push(2'd2, "units_reset", 4'd0, 1'b1, 1'b0, 1'b0);
    exp_push(2'd3, "tens_reset", 4'd0, 1'b1, 1'b0, 1'b0);
    @(negedge clock); c_ld = 1'b0; u_en = 1'b1;
    exp_push(2'd2, "units_0_borrow", 4'd0, 1'b1, 1'b1, 1'b0);
    exp_push(2'd3, "tens_5", 4'd5, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    exp_push(2'd2, "units_9", 4'd9, 1'b0, 1'b0, 1'b0);
    exp_push(2'd3, "tens_4", 4'd4, 1'b0, 1'b0, 1'b0);
    @(negedge clock); u_en = 1'b0; c_ld = 1'b1; u_lv = 4'd0; t_lv = 3'd0;
    exp_push(2'd2, "units_8", 4'd8, 1'b0, 1'b0, 1'b0);
    exp_push(2'd3, "tens_4_hold", 4'd4, 1'b0, 1'b0, 1'b0);
    @(negedge clock); c_ld = 1'b0; u_en = 1'b1;
    exp_push(2'd2, "units_00", 4'd0, 1'b1, 1'b1, 1'b0);
    exp_push(2'd3, "tens_00_borrow", 4'd0, 1'b1, 1'b1, 1'b0);
    @(negedge clock); u_en = 1'b0;
    exp_push(2'd2, "units_59", 4'd9, 1'b0, 1'b0, 1'b0);
    exp_push(2'd3, "tens_59", 4'd5, 1'b0, 1'b0, 1'b0);

    // Bounded drain of the scoreboard.
    for (int k = 0; k < 10 && sb_q.size() > 0; k++) begin
      @(negedge clock);
      #5;
    end
    @(negedge clock);
    #5;
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
